// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates IF fetches and MEM loads/stores onto a byte-wide RAM, little-endian.
// Optional macro MCTL_IF_PREEMPT_EN lets a MEM request abort an in-flight IF fetch.
module mem_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int RAM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_width,
    input  logic              mem_signed,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IF_RD  = 2'd1;
    localparam logic [1:0] MEM_RD = 2'd2;
    localparam logic [1:0] MEM_WR = 2'd3;

    // First edge at which read data for byte 0 is on ram_din.
    localparam logic [3:0] CAP_FIRST = 4'(RAM_RD_LAT + 1);
    localparam logic [3:0] RD_LAT    = 4'(RAM_RD_LAT);

    logic [1:0]        state;
    logic [ADDR_W-1:0] base;
    logic [3:0]        cnt;
    logic [3:0]        nbytes;
    logic [1:0]        width;
    logic              sgn;
    logic [31:0]       wdata;
    logic [23:0]       shreg;

    logic [3:0]  e;
    logic        rd_last;
    logic [31:0] full;
    logic [31:0] load_val;
    logic [7:0]  wbyte;
    logic [3:0]  mem_n;
    logic        preempt;

    assign if_stall  = if_req & ~if_done;
    assign mem_stall = mem_req & ~mem_done;

    // e is the index of the edge about to occur, counted from the accepting edge.
    assign e       = cnt + 4'd1;
    assign rd_last = (e == nbytes + RD_LAT);
    assign full    = {ram_din, shreg};
    assign wbyte   = wdata[{e[1:0], 3'b000} +: 8];

    always_comb begin
        mem_n = 4'd4;
        if (mem_width == 2'b00) begin
            mem_n = 4'd1;
        end else if (mem_width == 2'b01) begin
            mem_n = 4'd2;
        end
    end

    // Bytes arrive low first and shift down, so the loaded value sits in the top bytes of full.
    always_comb begin
        load_val = full;
        case (width)
            2'b00:   load_val = {{24{sgn & full[31]}}, full[31:24]};
            2'b01:   load_val = {{16{sgn & full[31]}}, full[31:16]};
            default: load_val = full;
        endcase
    end

`ifdef MCTL_IF_PREEMPT_EN
    assign preempt = (state == IF_RD) && mem_req && !rd_last;
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            base      <= '0;
            cnt       <= 4'd0;
            nbytes    <= 4'd0;
            width     <= 2'b00;
            sgn       <= 1'b0;
            wdata     <= 32'd0;
            shreg     <= 24'd0;
            ram_a     <= '0;
            ram_dout  <= 8'd0;
            ram_wr    <= 1'b0;
            if_data   <= 32'd0;
            mem_rdata <= 32'd0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A request still held during its own done cycle must not be re-serviced.
                    if (!if_done && !mem_done) begin
                        if (mem_req) begin
                            state    <= mem_we ? MEM_WR : MEM_RD;
                            base     <= mem_addr;
                            ram_a    <= mem_addr;
                            cnt      <= 4'd0;
                            nbytes   <= mem_n;
                            width    <= mem_width;
                            sgn      <= mem_signed;
                            wdata    <= mem_wdata;
                            ram_dout <= mem_wdata[7:0];
                            ram_wr   <= mem_we;
                        end else if (if_req) begin
                            state  <= IF_RD;
                            base   <= if_addr;
                            ram_a  <= if_addr;
                            cnt    <= 4'd0;
                            nbytes <= 4'd4;
                            width  <= 2'b10;
                            sgn    <= 1'b0;
                        end
                    end
                end
                IF_RD, MEM_RD: begin
                    if (preempt) begin
                        state <= IDLE;
                    end else begin
                        cnt <= e;
                        if (e < nbytes) begin
                            ram_a <= base + ADDR_W'(e);
                        end
                        if (e >= CAP_FIRST) begin
                            shreg <= full[31:8];
                        end
                        if (rd_last) begin
                            state <= IDLE;
                            if (state == IF_RD) begin
                                if_data <= full;
                                if_done <= 1'b1;
                            end else begin
                                mem_rdata <= load_val;
                                mem_done  <= 1'b1;
                            end
                        end
                    end
                end
                MEM_WR: begin
                    if (e < nbytes) begin
                        ram_a    <= base + ADDR_W'(e);
                        ram_dout <= wbyte;
                        cnt      <= e;
                    end else begin
                        ram_wr   <= 1'b0;
                        mem_done <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios plus random traffic against a byte-array reference model.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        if_stall;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_width;
    logic        mem_signed;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din = 8'h00;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    logic [7:0] ram [bit [31:0]];
    logic [7:0] ref_mem [bit [31:0]];
    wr_t wq[$];

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(32), .RAM_RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_width(mem_width), .mem_signed(mem_signed),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .mem_stall(mem_stall),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
    );

    function automatic logic [7:0] init_byte(bit [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_rd(bit [31:0] a);
        if (ram.exists(a)) return ram[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(bit [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic int nb(bit [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    // Little-endian assembly over consecutive addresses with 32-bit wrap.
    function automatic logic [31:0] ref_load(bit [31:0] a, int n, bit s);
        logic [31:0] v;
        v = 32'd0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_rd(32'(a + 32'(k)));
        if (s && n == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
        if (s && n == 2 && v[15]) v[31:16] = 16'hFFFF;
        return v;
    endfunction

    // Byte-wide RAM with one cycle of read latency.
    always @(posedge clk) begin
        wr_t ent;
        if (ram_wr) begin
            ram[ram_a] = ram_dout;
            ent.a = ram_a;
            ent.d = ram_dout;
            wq.push_back(ent);
        end
        ram_din <= ram_rd(ram_a);
    end

    task automatic preload(input bit [31:0] a, input bit [7:0] d);
        ram[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit is_mem, input bit scr, output int edges,
                             output bit seen, output bit stall_ok, output bit other_seen);
        edges = 0;
        seen = 1'b0;
        stall_ok = 1'b1;
        other_seen = 1'b0;
        while (!seen && edges < 30) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (scr && edges == 1) begin
                if (is_mem) begin
                    mem_addr   = $urandom;
                    mem_wdata  = $urandom;
                    mem_width  = 2'($urandom);
                    mem_signed = 1'($urandom);
                end else begin
                    if_addr = $urandom;
                end
            end
            seen = is_mem ? (mem_done === 1'b1) : (if_done === 1'b1);
            if (is_mem ? (if_done === 1'b1) : (mem_done === 1'b1)) other_seen = 1'b1;
            if (!seen && ((is_mem ? mem_stall : if_stall) !== 1'b1)) stall_ok = 1'b0;
            if (seen && ((is_mem ? mem_stall : if_stall) !== 1'b0)) stall_ok = 1'b0;
        end
    endtask

    task automatic if_txn(input string tag, input logic [31:0] a, input bit scr, output logic [31:0] exp);
        int edges;
        bit seen, sok, oth;
        exp = ref_load(a, 4, 1'b0);
        if_req = 1'b1;
        if_addr = a;
        wait_done(1'b0, scr, edges, seen, sok, oth);
        chk({tag, " seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, edges, 32'd6);
        chk({tag, " stall"}, 32'(sok), 32'd1);
        chk({tag, " data"}, if_data, exp);
        if_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " pulse"}, 32'(if_done), 32'd0);
    endtask

    task automatic mem_txn(input string tag, input bit we, input bit [1:0] w, input bit s,
                           input logic [31:0] a, input logic [31:0] wd, input bit scr,
                           output logic [31:0] exp);
        int edges, n;
        bit seen, sok, oth;
        n = nb(w);
        exp = ref_load(a, n, s);
        wq.delete();
        mem_req = 1'b1;
        mem_we = we;
        mem_width = w;
        mem_signed = s;
        mem_addr = a;
        mem_wdata = wd;
        wait_done(1'b1, scr, edges, seen, sok, oth);
        chk({tag, " seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, edges, we ? 32'(n + 1) : 32'(n + 2));
        chk({tag, " stall"}, 32'(sok), 32'd1);
        if (we) begin
            chk({tag, " wr_off"}, 32'(ram_wr), 32'd0);
            chk({tag, " wr_count"}, 32'(wq.size()), 32'(n));
            for (int k = 0; k < n; k++) begin
                if (k < wq.size()) begin
                    chk({tag, " wr_addr"}, wq[k].a, 32'(a + 32'(k)));
                    chk({tag, " wr_byte"}, 32'(wq[k].d), 32'(wd[8*k +: 8]));
                end
                ref_mem[32'(a + 32'(k))] = wd[8*k +: 8];
            end
        end else begin
            chk({tag, " rdata"}, mem_rdata, exp);
        end
        mem_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " pulse"}, 32'(mem_done), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x, last_if, last_mem, old_if, a;
        int edges, kind;
        bit seen, sok, oth, done_seen;
        bit [1:0] w;

        rst = 1'b0;
        if_req = 1'b0;
        if_addr = 32'd0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        mem_width = 2'b00;
        mem_signed = 1'b0;
        mem_addr = 32'd0;
        mem_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst ram_wr", 32'(ram_wr), 32'd0);
        chk("rst ram_a", ram_a, 32'd0);
        chk("rst if_data", if_data, 32'd0);
        chk("rst mem_rdata", mem_rdata, 32'd0);
        chk("rst dones", {30'd0, if_done, mem_done}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        preload(32'h100, 8'h13);
        preload(32'h101, 8'h05);
        preload(32'h102, 8'h00);
        preload(32'h103, 8'h00);
        if_txn("fetch100", 32'h100, 1'b0, last_if);
        chk("fetch100 const", if_data, 32'h00000513);

        preload(32'h2003, 8'hF0);
        mem_txn("lb_s", 1'b0, 2'b00, 1'b1, 32'h2003, 32'd0, 1'b0, x);
        chk("lb_s const", mem_rdata, 32'hFFFFFFF0);
        mem_txn("lb_u", 1'b0, 2'b00, 1'b0, 32'h2003, 32'd0, 1'b0, x);
        chk("lb_u const", mem_rdata, 32'h000000F0);

        mem_txn("sw3000", 1'b1, 2'b10, 1'b0, 32'h3000, 32'hDEADBEEF, 1'b0, x);
        mem_txn("lw3000", 1'b0, 2'b10, 1'b0, 32'h3000, 32'd0, 1'b0, x);
        chk("lw3000 const", mem_rdata, 32'hDEADBEEF);
        chk("if_data hold", if_data, last_if);

        preload(32'hFFFFFFFF, 8'h34);
        preload(32'h00000000, 8'h92);
        mem_txn("lh_wrap", 1'b0, 2'b01, 1'b1, 32'hFFFFFFFF, 32'd0, 1'b0, x);
        chk("lh_wrap const", mem_rdata, 32'hFFFF9234);

        // Simultaneous requests: MEM first, bubble, then IF.
        if_req = 1'b1;
        if_addr = 32'h3000;
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_width = 2'b01;
        mem_signed = 1'b0;
        mem_addr = 32'h100;
        wait_done(1'b1, 1'b0, edges, seen, sok, oth);
        chk("sim mem latency", edges, 32'd4);
        chk("sim mem data", mem_rdata, 32'h00000513);
        chk("sim if waits", {30'd0, oth, if_stall}, 32'd1);
        mem_req = 1'b0;
        wait_done(1'b0, 1'b0, edges, seen, sok, oth);
        chk("sim if latency", edges, 32'd7);
        chk("sim if stall", 32'(sok), 32'd1);
        chk("sim if data", if_data, 32'hDEADBEEF);
        if_req = 1'b0;
        @(negedge clk);

        // MEM request raised two edges into a fetch; if_addr changes at the same moment.
        if_req = 1'b1;
        if_addr = 32'h100;
        repeat (2) @(negedge clk);
        if_addr = 32'h3000;
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_width = 2'b00;
        mem_signed = 1'b0;
        mem_addr = 32'h2003;
`ifdef MCTL_IF_PREEMPT_EN
        wait_done(1'b1, 1'b0, edges, seen, sok, oth);
        chk("pre mem latency", edges, 32'd4);
        chk("pre no if_done", 32'(oth), 32'd0);
        chk("pre mem data", mem_rdata, 32'h000000F0);
        chk("pre if_data kept", if_data, 32'hDEADBEEF);
        mem_req = 1'b0;
        wait_done(1'b0, 1'b0, edges, seen, sok, oth);
        chk("pre if latency", edges, 32'd7);
        chk("pre if data", if_data, 32'hDEADBEEF);
        if_req = 1'b0;
`else
        wait_done(1'b0, 1'b0, edges, seen, sok, oth);
        chk("mid if latency", edges, 32'd4);
        chk("mid no mem_done", 32'(oth), 32'd0);
        chk("mid if data", if_data, 32'h00000513);
        if_req = 1'b0;
        wait_done(1'b1, 1'b0, edges, seen, sok, oth);
        chk("mid mem latency", edges, 32'd4);
        chk("mid mem data", mem_rdata, 32'h000000F0);
        mem_req = 1'b0;
`endif
        @(negedge clk);

        // Reset asserted while the third byte of a store is on the bus.
        wq.delete();
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_width = 2'b10;
        mem_addr = 32'h5000;
        mem_wdata = 32'h11223344;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst mid ram_wr", 32'(ram_wr), 32'd0);
        chk("rst mid done", 32'(mem_done), 32'd0);
        chk("rst mid ram_a", ram_a, 32'd0);
        chk("rst mid wr_count", 32'(wq.size()), 32'd2);
        ref_mem[32'h5000] = 8'h44;
        ref_mem[32'h5001] = 8'h33;
        mem_req = 1'b0;
        done_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (mem_done !== 1'b0) done_seen = 1'b1;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (mem_done !== 1'b0) done_seen = 1'b1;
        end
        chk("rst no done", 32'(done_seen), 32'd0);
        chk("rst mem_rdata", mem_rdata, 32'd0);
        chk("rst if_data", if_data, 32'd0);
        mem_txn("post_rst lw", 1'b0, 2'b10, 1'b0, 32'h5000, 32'd0, 1'b0, last_mem);
        if_txn("post_rst if", 32'h100, 1'b0, last_if);

        // Random traffic; unrelated output registers must hold their last value.
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else a = 32'h6000 + 32'($urandom_range(0, 31));
            w = 2'($urandom);
            x = $urandom;
            if (kind == 0) begin
                old_if = last_if;
                if_txn($sformatf("rnd%0d if", i), a, 1'b1, last_if);
                chk($sformatf("rnd%0d mem hold", i), mem_rdata, last_mem);
            end else begin
                old_if = last_if;
                if (kind == 1) mem_txn($sformatf("rnd%0d ld", i), 1'b0, w, 1'($urandom), a, x, 1'b1, last_mem);
                else mem_txn($sformatf("rnd%0d st", i), 1'b1, w, 1'b0, a, x, 1'b1, old_if);
                chk($sformatf("rnd%0d if hold", i), if_data, last_if);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Memory controller between the pipeline and a byte-wide single-port RAM. It arbitrates IF instruction fetches and MEM load/store requests and serialises each 32-bit access into byte transfers. It also produces the if_stall and mem_stall signals that the stall controller prioritises. Little-endian; the MEM port takes priority over the IF port.

Parameters:
ADDR_W, 32, width of all address ports.
RAM_RD_LAT, 1, cycles from the RAM sampling an address to read data on ram_din (fixed at 1 in this revision).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
if_req  in  1  fetch request, held until if_done
if_addr  in  ADDR_W  fetch address (any alignment)
if_data  out  32  fetched word, valid when if_done=1
if_done  out  1  one-cycle completion pulse
if_stall  out  1  if_req & ~if_done
mem_req  in  1  load/store request, held until mem_done
mem_we  in  1  1=store, 0=load
mem_width  in  2  00 byte, 01 half, 10/11 word
mem_signed  in  1  sign-extend byte/half loads
mem_addr  in  ADDR_W  load/store address
mem_wdata  in  32  store data; byte k = bits [8k+7:8k]
mem_rdata  out  32  load result, valid when mem_done=1
mem_done  out  1  one-cycle completion pulse
mem_stall  out  1  mem_req & ~mem_done
ram_a  out  ADDR_W  RAM address, registered
ram_dout  out  8  RAM write byte, registered
ram_wr  out  1  RAM write enable, registered
ram_din  in  8  RAM read byte

Behaviour:
- Reset (async, rst=0): state IDLE; ram_a, ram_dout, ram_wr, if_data, mem_rdata, if_done, mem_done, byte counter and shift register all cleared. ram_wr drops immediately. An in-flight transfer is abandoned with no done pulse.
- States: IDLE, IF_RD, MEM_RD, MEM_WR.
- IDLE arbitration at edge E0:
  - mem_req=1 has priority; go to MEM_WR if mem_we=1, else MEM_RD.
  - Otherwise if_req=1 goes to IF_RD.
  - Address, width, signedness and wdata are latched at E0. Later input changes are ignored until done.
- Byte count N: IF=4; MEM by width 1/2/4. Byte k address = addr+k, wrapping modulo 2^ADDR_W.
- Read: byte k address is driven after edge E_k. Byte k is captured from ram_din at E_{k+2}. The result and done are asserted at E_{N+1}, so a word read takes 5 cycles and done is visible in cycle 6 after the request.
- Load result:
  - byte: zero- or sign-extended from bit 7.
  - half: zero- or sign-extended from bit 15.
  - if_data is always the full 4-byte word.
- Write: byte k is driven with ram_wr=1 after E_k. ram_wr=0 after E_N, and mem_done is asserted at E_N.
- done is a single-cycle pulse. The FSM is back in IDLE in the done cycle, and IDLE ignores both requests during any cycle in which either done is high. This prevents re-servicing a request that is still held, so there is a one-cycle bubble between back-to-back transactions.
- ram_wr=0 in IDLE and in all read states. ram_a holds its last value in IDLE.
- if_data and mem_rdata hold their value until the next completion on that port.
- Simultaneous IF and MEM requests: MEM is served first and IF stalls throughout. IF is served starting at the first IDLE edge after the mem_done cycle.
- Stall outputs are combinational from req and done. They never assert while the corresponding req is 0.

Optional Feature:
- Macro: MCTL_IF_PREEMPT_EN.
- Defined: if mem_req rises while in IF_RD, the IF fetch is aborted at the next edge without an if_done pulse. The FSM passes through IDLE (one cycle, ram_wr=0) and serves MEM. The IF fetch then restarts from byte 0 using the current if_addr.
- Undefined: an IF transfer always runs to completion before MEM is served.

Test Plan:
- Word fetch: if_addr=0x100, RAM bytes 0x13,0x05,0x00,0x00 -> if_data=0x00000513, if_done pulses once in cycle 6, if_stall high cycles 1-5.
- Signed byte load: mem_addr=0x2003, byte 0xF0, mem_signed=1 -> mem_rdata=0xFFFFFFF0. Repeat with mem_signed=0 -> 0x000000F0.
- Word store: mem_addr=0x3000, wdata=0xDEADBEEF -> ram_wr high 4 cycles with bytes EF,BE,AD,DE at 0x3000-0x3003; mem_done in cycle 5.
- Simultaneous IF and MEM requests in the same cycle -> MEM served first, one-cycle bubble, then IF. Without MCTL_IF_PREEMPT_EN, a mem_req raised mid-fetch waits for if_done. With it, the fetch aborts with no if_done and restarts after mem_done.
- Half load at 0xFFFFFFFF -> bytes read from 0xFFFFFFFF then 0x00000000, correctly assembled.
- rst low during the third byte of a store -> ram_wr=0 immediately, no done pulse; after release, IDLE accepts a new request.
